// File: rtl/dmem_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | dmem_rr_arbiter: round-robin share of one data-memory port, one        |
// | outstanding transaction, sticky timeout error.   Rev 1.0               |
// +------------------------------------------------------------------------+
module dmem_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  input  logic [NUM_REQ-1:0]               req_we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata_i,
  output logic [NUM_REQ-1:0]               req_grant_o,
  output logic [NUM_REQ-1:0]               resp_valid_o,
  output logic [DATA_WIDTH-1:0]            resp_data_o,
  output logic                             resp_err_o,
  output logic                             mem_valid_o,
  output logic                             mem_we_o,
  output logic [ADDR_WIDTH-1:0]            mem_addr_o,
  output logic [DATA_WIDTH-1:0]            mem_wdata_o,
  input  logic                             mem_ready_i,
  input  logic                             mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]            mem_rdata_i,
  output logic                             error_o
);

  localparam int c_IW = $clog2(NUM_REQ);
  localparam int c_CW = $clog2(TIMEOUT + 1);
  localparam logic [c_CW-1:0] c_TMO = c_CW'(TIMEOUT);

  localparam logic [1:0] c_S_IDLE  = 2'd0;
  localparam logic [1:0] c_S_ISSUE = 2'd1;
  localparam logic [1:0] c_S_WAIT  = 2'd2;

  logic [1:0]            r_state;
  logic [c_IW-1:0]       r_last;
  logic [c_IW-1:0]       r_owner;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_we;
  logic [c_CW-1:0]       r_cnt;
  logic [NUM_REQ-1:0]    r_resp_valid;
  logic [DATA_WIDTH-1:0] r_resp_data;
  logic                  r_resp_err;
  logic                  r_error;

  logic                  w_any;
  logic [c_IW-1:0]       w_win;
  logic [c_IW-1:0]       w_cand;
  logic [NUM_REQ-1:0]    w_grant;
  logic [NUM_REQ-1:0]    w_owner_oh;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;

  // Scan starts one past the last winner so every core gets a turn.
  always_comb begin
    w_any  = 1'b0;
    w_win  = '0;
    w_cand = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_cand = c_IW'((int'(r_last) + i) % NUM_REQ);
      if (!w_any && req_valid_i[w_cand]) begin
        w_any = 1'b1;
        w_win = w_cand;
      end
    end
  end

  // Gated by reset so the combinational grant is quiet while reset is held.
  always_comb begin
    w_grant = '0;
    if (reset && (r_state == c_S_IDLE) && w_any) begin
      w_grant[w_win] = 1'b1;
    end
  end

  always_comb begin
    w_owner_oh          = '0;
    w_owner_oh[r_owner] = 1'b1;
  end

  assign w_sel_addr  = req_addr_i[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_sel_wdata = req_wdata_i[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= c_S_IDLE;
      r_last       <= c_IW'(NUM_REQ - 1);
      r_owner      <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_we         <= 1'b0;
      r_cnt        <= '0;
      r_resp_valid <= '0;
      r_resp_data  <= '0;
      r_resp_err   <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_resp_valid <= '0;
      r_resp_err   <= 1'b0;
      case (r_state)
        c_S_IDLE: begin
          if (w_any) begin
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_we    <= req_we_i[w_win];
            r_owner <= w_win;
            r_last  <= w_win;
            r_state <= c_S_ISSUE;
          end
        end
        c_S_ISSUE: begin
          if (mem_ready_i) begin
            r_cnt   <= '0;
            r_state <= c_S_WAIT;
          end
        end
        c_S_WAIT: begin
          // A completion in the final counted cycle still beats the abort.
          if (mem_rvalid_i) begin
            r_resp_valid <= w_owner_oh;
            r_resp_data  <= r_we ? '0 : mem_rdata_i;
            r_state      <= c_S_IDLE;
          end else if (r_cnt == c_TMO) begin
            r_resp_valid <= w_owner_oh;
            r_resp_err   <= 1'b1;
            r_resp_data  <= '0;
            r_error      <= 1'b1;
            r_state      <= c_S_IDLE;
          end else begin
            r_cnt <= r_cnt + c_CW'(1);
          end
        end
        default: r_state <= c_S_IDLE;
      endcase
    end
  end

  assign req_grant_o  = w_grant;
  assign resp_valid_o = r_resp_valid;
  assign resp_data_o  = r_resp_data;
  assign resp_err_o   = r_resp_err;
  assign mem_valid_o  = (r_state == c_S_ISSUE);
  assign mem_we_o     = r_we;
  assign mem_addr_o   = r_addr;
  assign mem_wdata_o  = r_wdata;
  assign error_o      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_dmem_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_dmem_rr_arbiter: vector table, corner sequences and random          |
// | transactions against a transaction-level model.   Rev 1.0              |
// +------------------------------------------------------------------------+
module tb_dmem_rr_arbiter;

  localparam int N   = 4;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    req_valid_i, req_we_i;
  logic [127:0]  req_addr_i, req_wdata_i;
  logic [3:0]    req_grant_o, resp_valid_o;
  logic [31:0]   resp_data_o;
  logic          resp_err_o;
  logic          mem_valid_o, mem_we_o;
  logic [31:0]   mem_addr_o, mem_wdata_o;
  logic          mem_ready_i, mem_rvalid_i;
  logic [31:0]   mem_rdata_i;
  logic          error_o;

  int total = 0;
  int bad   = 0;
  int m_last;
  logic m_err;

  dmem_rr_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .req_grant_o(req_grant_o), .resp_valid_o(resp_valid_o),
    .resp_data_o(resp_data_o), .resp_err_o(resp_err_o),
    .mem_valid_o(mem_valid_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ready_i(mem_ready_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .error_o(error_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]  v;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          rdy;
    int          rv;
    logic [31:0] rd;
    int          ew;
    logic [31:0] edata;
    logic        eerr;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Winner = first valid core in the rotation that begins after the last winner.
  function automatic int pick(input logic [3:0] v, input int last);
    int order[$];
    int c;
    for (int i = 1; i <= N; i++) order.push_back((last + i) % N);
    while (order.size() > 0) begin
      c = order.pop_front();
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Starts and finishes at a negedge with the DUT idle.
  task automatic txn(input string nm, input logic [3:0] v, input logic [3:0] we,
                     input logic [127:0] a, input logic [127:0] wd,
                     input int rdy, input int rv, input logic [31:0] rd,
                     input int ew, input logic [31:0] edata, input logic eerr);
    logic [31:0] s_addr, s_wd;
    logic        s_we, ok_stable, ok_quiet, got, rerr;
    logic [3:0]  rvec;
    logic [31:0] rdat;
    int          lat, elat;
    elat = 2 + rdy + ((rv <= TMO) ? rv + 1 : TMO + 1);
    req_valid_i = v; req_we_i = we; req_addr_i = a; req_wdata_i = wd;
    #1;
    chk({nm, " grant"}, {28'd0, req_grant_o}, 32'd1 << ew);
    cycle();
    lat = 1; ok_stable = 1'b1; ok_quiet = 1'b1;
    s_addr = mem_addr_o; s_wd = mem_wdata_o; s_we = mem_we_o;
    for (int k = 0; k <= rdy; k++) begin
      if (mem_valid_o !== 1'b1 || mem_addr_o !== s_addr || mem_wdata_o !== s_wd || mem_we_o !== s_we)
        ok_stable = 1'b0;
      if (req_grant_o !== 4'd0) ok_quiet = 1'b0;
      mem_ready_i = (k == rdy);
      cycle();
      lat++;
    end
    mem_ready_i = 1'b0;
    chk({nm, " mem_addr"}, s_addr, a[ew*32 +: 32]);
    chk({nm, " mem_wdata"}, s_wd, wd[ew*32 +: 32]);
    chk({nm, " mem_we"}, {31'd0, s_we}, {31'd0, we[ew]});
    got = 1'b0; rvec = '0; rdat = '0; rerr = 1'b0;
    for (int k = 0; k < TMO + 8 && !got; k++) begin
      if (resp_valid_o !== 4'd0) begin
        got = 1'b1; rvec = resp_valid_o; rdat = resp_data_o; rerr = resp_err_o;
      end else begin
        if (req_grant_o !== 4'd0 || mem_valid_o !== 1'b0) ok_quiet = 1'b0;
        mem_rvalid_i = (k == rv);
        mem_rdata_i  = (k == rv) ? rd : $urandom;
        cycle();
        lat++;
      end
    end
    mem_rvalid_i = 1'b0;
    req_valid_i  = 4'd0;
    chk({nm, " resp_valid"}, {28'd0, rvec}, 32'd1 << ew);
    chk({nm, " resp_data"}, rdat, edata);
    chk({nm, " resp_err"}, {31'd0, rerr}, {31'd0, eerr});
    chk({nm, " latency"}, lat, elat);
    chk({nm, " stable"}, {31'd0, ok_stable}, 32'd1);
    chk({nm, " quiet"}, {31'd0, ok_quiet}, 32'd1);
    m_err = m_err | eerr;
    cycle();
    chk({nm, " pulse_end"}, {28'd0, resp_valid_o}, 32'd0);
    chk({nm, " error_o"}, {31'd0, error_o}, {31'd0, m_err});
  endtask

  task automatic chk_quiet_outputs(input string nm);
    chk({nm, " grant"}, {28'd0, req_grant_o}, 32'd0);
    chk({nm, " resp_valid"}, {28'd0, resp_valid_o}, 32'd0);
    chk({nm, " mem_valid"}, {31'd0, mem_valid_o}, 32'd0);
    chk({nm, " mem_addr"}, mem_addr_o, 32'd0);
    chk({nm, " resp_data"}, resp_data_o, 32'd0);
    chk({nm, " error_o"}, {31'd0, error_o}, 32'd0);
  endtask

  initial begin
    vec_t        tbl[12];
    logic [127:0] a, wd;
    logic [3:0]   v, we;
    logic [31:0]  rd, edata;
    int           ew, rdy, rv;

    tbl[0]  = '{4'hF, 4'h0, 32'h0000_0010, 32'h0, 0, 0, 32'h1111_1111, 0, 32'h1111_1111, 1'b0};
    tbl[1]  = '{4'hF, 4'hF, 32'h0000_0020, 32'hA5A5_0001, 0, 0, 32'h9999_9999, 1, 32'h0, 1'b0};
    tbl[2]  = '{4'hF, 4'h0, 32'h0000_0030, 32'h0, 1, 2, 32'h2222_2222, 2, 32'h2222_2222, 1'b0};
    tbl[3]  = '{4'hF, 4'h0, 32'h0000_0034, 32'h0, 2, 1, 32'h3333_3333, 3, 32'h3333_3333, 1'b0};
    tbl[4]  = '{4'hF, 4'h0, 32'h0000_0038, 32'h0, 0, 0, 32'h4444_4444, 0, 32'h4444_4444, 1'b0};
    tbl[5]  = '{4'h8, 4'h0, 32'h0000_0300, 32'h0, 0, 0, 32'h5555_5555, 3, 32'h5555_5555, 1'b0};
    tbl[6]  = '{4'h9, 4'h0, 32'h0000_0000, 32'h0, 0, 0, 32'h6666_6666, 0, 32'h6666_6666, 1'b0};
    tbl[7]  = '{4'h8, 4'h0, 32'h0000_0304, 32'h0, 0, 0, 32'h7777_7777, 3, 32'h7777_7777, 1'b0};
    tbl[8]  = '{4'h4, 4'h0, 32'h0000_0100, 32'h0, 0, 0, 32'hCAFE_0001, 2, 32'hCAFE_0001, 1'b0};
    tbl[9]  = '{4'h2, 4'h2, 32'h0000_0040, 32'h0000_0055, 5, 0, 32'hBEEF_BEEF, 1, 32'h0, 1'b0};
    tbl[10] = '{4'h1, 4'h0, 32'h0000_0080, 32'h0, 0, 99, 32'h0, 0, 32'h0, 1'b1};
    tbl[11] = '{4'h1, 4'h0, 32'h0000_0084, 32'h0, 0, 3, 32'h1234_5678, 0, 32'h1234_5678, 1'b0};

    reset = 1'b0;
    req_valid_i = 4'hF; req_we_i = 4'h0; req_addr_i = '1; req_wdata_i = '1;
    mem_ready_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk);
    chk_quiet_outputs("reset_a");
    cycle(); cycle();
    chk_quiet_outputs("reset_b");
    reset = 1'b1;
    req_valid_i = 4'h0; mem_ready_i = 1'b0; mem_rvalid_i = 1'b0;
    cycle();
    m_last = N - 1;
    m_err  = 1'b0;

    for (int t = 0; t < 12; t++) begin
      for (int k = 0; k < N; k++) begin
        a[k*32 +: 32]  = (k == tbl[t].ew) ? tbl[t].addr  : (32'hDEAD_0000 | 32'(k));
        wd[k*32 +: 32] = (k == tbl[t].ew) ? tbl[t].wdata : (32'hF00D_0000 | 32'(k));
      end
      txn($sformatf("vec%0d", t), tbl[t].v, tbl[t].we, a, wd, tbl[t].rdy, tbl[t].rv,
          tbl[t].rd, tbl[t].ew, tbl[t].edata, tbl[t].eerr);
      m_last = tbl[t].ew;
    end

    // A completion with nothing outstanding must not produce a response.
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD0_0BAD;
    cycle();
    mem_rvalid_i = 1'b0;
    cycle();
    chk("late_rvalid resp", {28'd0, resp_valid_o}, 32'd0);
    chk("late_rvalid error_o", {31'd0, error_o}, 32'd1);

    // Reset while waiting for the memory: abort silently, pointer back to N-1.
    req_valid_i = 4'h2; req_we_i = 4'h0;
    cycle();
    req_valid_i = 4'h0; mem_ready_i = 1'b1;
    cycle();
    mem_ready_i = 1'b0;
    cycle();
    reset = 1'b0;
    req_valid_i = 4'hF;
    #1;
    chk_quiet_outputs("midreset");
    cycle();
    chk("midreset held grant", {28'd0, req_grant_o}, 32'd0);
    reset = 1'b1; req_valid_i = 4'h0;
    cycle();
    chk("postreset resp_a", {28'd0, resp_valid_o}, 32'd0);
    cycle();
    chk("postreset resp_b", {28'd0, resp_valid_o}, 32'd0);
    m_last = N - 1;
    m_err  = 1'b0;
    a = {32'h4, 32'h3, 32'h2, 32'h1};
    txn("postreset", 4'hF, 4'h0, a, '0, 0, 0, 32'h0BAD_F00D, 0, 32'h0BAD_F00D, 1'b0);
    m_last = 0;

    for (int r = 0; r < 40; r++) begin
      v   = 4'($urandom_range(1, 15));
      we  = 4'($urandom);
      for (int k = 0; k < N; k++) begin
        a[k*32 +: 32]  = $urandom;
        wd[k*32 +: 32] = $urandom;
      end
      rdy = $urandom_range(0, 3);
      rv  = $urandom_range(0, TMO + 2);
      rd  = $urandom;
      ew  = pick(v, m_last);
      if (rv > TMO)   edata = 32'h0;
      else if (we[ew]) edata = 32'h0;
      else            edata = rd;
      txn($sformatf("rnd%0d", r), v, we, a, wd, rdy, rv, rd, ew, edata, rv > TMO);
      m_last = ew;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
